// File: rtl/log_mult_pkg.sv
// Shared definitions for the log-multiplier datapath: characteristic width
// helper and the k/x/zero word passed between the log, adder and antilog stages.
package log_mult_pkg;

    // Reference geometry of the log-multiplier datapath
    localparam int LOG_DWIDTH  = 16;
    localparam int LOG_M_WIDTH = 6;

    // k needs one bit beyond the leading-one index so that a rounding carry
    // can push it to DWIDTH
    function automatic int k_width(input int dwidth);
        return $clog2(dwidth) + 1;
    endfunction

    localparam int LOG_K_WIDTH = k_width(LOG_DWIDTH);

    // Log-domain word exchanged with the adder stage and antilog_conv
    typedef struct packed {
        logic [LOG_K_WIDTH-1:0] k;
        logic [LOG_M_WIDTH-1:0] x;
        logic                   zero;
    } log_word_t;

endpackage

// File: rtl/log_conv_lod.sv
// Leading-one detector: index of the most-significant set bit plus an
// all-zero flag. Purely combinational; index is 0 for a zero operand.
module lod
    import log_mult_pkg::*;
#(
    parameter  int DWIDTH = 16,
    localparam int IW     = $clog2(DWIDTH)
) (
    input  logic [DWIDTH-1:0] data,
    output logic [IW-1:0]     index,
    output logic              zero
);

    // Scan upward so the highest set bit wins
    always_comb begin
        index = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            if (data[i]) begin
                index = IW'(i);
            end
        end
        zero = ~|data;
    end

endmodule

// File: rtl/log_conv.sv
// Linear-to-log converter: unsigned operand -> characteristic k (leading-one
// position) and left-aligned fraction x. Two pipeline stages with a
// valid/ready handshake and no skid buffer (in_ready depends on out_ready).
// Optional macro LOG_CONV_ROUND_EN: round x half-up on the first discarded
// bit, carrying into k on overflow; otherwise x is plainly truncated.
module log_conv
    import log_mult_pkg::*;
#(
    parameter  int DWIDTH  = 16,
    parameter  int M_WIDTH = 6,
    localparam int K_WIDTH = k_width(DWIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWIDTH-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [K_WIDTH-1:0] out_k,
    output logic [M_WIDTH-1:0] out_x,
    output logic               out_zero
);

    localparam int IW = $clog2(DWIDTH);
    // normalised operand with M_WIDTH+1 zero bits appended, so x and the
    // round bit are always available even when k < M_WIDTH
    localparam int EW = DWIDTH + M_WIDTH + 1;

    logic              adv1;
    logic              adv2;

    logic              s1_valid_reg;
    logic [DWIDTH-1:0] s1_data_reg;
    logic [IW-1:0]     s1_k_reg;
    logic              s1_zero_reg;

    logic [IW-1:0]     lod_index;
    logic              lod_zero;

    logic [IW-1:0]     shamt;
    logic [DWIDTH-1:0] norm;
    logic [EW-1:0]     norm_ext;
    logic [M_WIDTH-1:0] x_trunc;
    logic [K_WIDTH-1:0] k_ext;
    logic [M_WIDTH-1:0] x_next;
    logic [K_WIDTH-1:0] k_next;

    // A stage advances when its downstream register is empty or draining
    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid_reg | adv2;
    assign in_ready = adv1;

    lod #(
        .DWIDTH (DWIDTH)
    ) u_lod (
        .data  (in_data),
        .index (lod_index),
        .zero  (lod_zero)
    );

    // Stage 1: capture operand with its leading-one index and zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_k_reg     <= '0;
            s1_zero_reg  <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= in_data;
                s1_k_reg    <= lod_index;
                s1_zero_reg <= lod_zero;
            end
        end
    end

    // Stage 2 datapath: normalise so the leading one sits at the MSB, then
    // take the next M_WIDTH bits as the fraction
    always_comb begin
        shamt    = IW'(DWIDTH - 1) - s1_k_reg;
        norm     = s1_data_reg << shamt;
        norm_ext = {norm, {(M_WIDTH + 1){1'b0}}};
        // bits [EW-2 -: M_WIDTH] sit just below the leading one
        x_trunc  = M_WIDTH'(norm_ext >> DWIDTH);
        k_ext    = {1'b0, s1_k_reg};
    end

`ifdef LOG_CONV_ROUND_EN
    logic               round_bit;
    logic [M_WIDTH:0]   x_sum;

    // Round half-up on the first discarded bit; a carry out of x bumps k
    always_comb begin
        round_bit = norm_ext[DWIDTH-1];
        x_sum     = {1'b0, x_trunc} + (M_WIDTH + 1)'(round_bit);
        if (x_sum[M_WIDTH]) begin
            x_next = '0;
            k_next = k_ext + K_WIDTH'(1);
        end else begin
            x_next = x_sum[M_WIDTH-1:0];
            k_next = k_ext;
        end
    end
`else
    // Pure truncation
    always_comb begin
        x_next = x_trunc;
        k_next = k_ext;
    end
`endif

    // Stage 2 register: results held stable while stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_k     <= '0;
            out_x     <= '0;
            out_zero  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_k    <= k_next;
                out_x    <= x_next;
                out_zero <= s1_zero_reg;
            end
        end
    end

endmodule

// File: doc/log_conv.md
Name: log_conv

Overview:
- Forward (linear-to-log) converter for the log-multiplier datapath; counterpart of the antilog stage.
- Takes an unsigned DWIDTH-bit operand and produces the characteristic k (leading-one position) and the M_WIDTH-bit truncated fraction x (bits below the leading one, left-aligned).
- Two-stage pipeline with valid/ready handshake.
- Two instances feed the k/x adders ahead of the antilog stage.

Parameters:
- DWIDTH, 16, operand width (8 or 16).
- M_WIDTH, 6, fraction bits kept (t); t=6 is the accuracy/area point.
- K_WIDTH, $clog2(DWIDTH)+1, k output width; localparam, not overridable.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  converter accepts operand this cycle.
- in_data  input  DWIDTH  unsigned operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_k  output  K_WIDTH  characteristic (leading-one index).
- out_x  output  M_WIDTH  fraction.
- out_zero  output  1  operand was zero; out_k/out_x are 0.

Behaviour:
- Reset (async assert, sync-safe release): all valid flags = 0, out_k = 0, out_x = 0, out_zero = 0. Reset mid-operation discards in-flight data.
- Stage 1, on accept (in_valid & in_ready):
  - registers in_data, k = index of the most-significant 1, and zero = (in_data == 0).
- Stage 2:
  - shifts the operand left by (DWIDTH-1-k) to drop the leading one.
  - x = top M_WIDTH bits of the remaining fraction; zero-padded on the right when k < M_WIDTH.
  - Registers the results to the out_* ports.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- Handshake:
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - Output data is held stable while out_valid & ~out_ready.
  - Simultaneous accept and drain in the same cycle is allowed and loses no data.
- Zero operand: out_zero = 1, out_k = 0, out_x = 0. Downstream forces the product to 0.
- Operand = 1: k = 0, x = 0, out_zero = 0.
- Without rounding, out_k ≤ DWIDTH-1. The MSB of K_WIDTH is used only by the rounding feature.
- in_data is sampled only on accept. Changes while in_ready = 0 are ignored.

Optional Feature:
- Macro LOG_CONV_ROUND_EN.
- Defined: x is rounded half-up using the first discarded fraction bit.
  - If the round overflows x (all ones + 1): x = 0 and k = k+1 (e.g. k may reach DWIDTH).
  - Rounding happens in stage 2; latency is unchanged.
- Undefined: pure truncation. No rounding logic is synthesised.

Decomposition:
- Package log_mult_pkg:
  - localparam/function for K_WIDTH (clog2(DWIDTH)+1).
  - typedef log_word_t, a struct of k, x and zero, shared with antilog_conv and the adder stage.
- Sub-module lod (leading-one detector):
  - parameter DWIDTH; outputs index and zero flag.
  - Purely combinational; used by stage 1.

Test Plan:
- DWIDTH=16, M_WIDTH=6, in_data=0x00B4, out_ready=1 → two cycles later out_k=7, out_x=6'b011010 (26), out_zero=0.
- in_data=0x0000 → out_zero=1, out_k=0, out_x=0. in_data=0x0001 → out_k=0, out_x=0, out_zero=0.
- in_data=0xFFFF:
  - Without the macro → out_k=15, out_x=63.
  - With LOG_CONV_ROUND_EN → out_k=16, out_x=0.
- Back-to-back stream 0x0003, 0x8000, 0x0005 with out_ready=1 → one result per cycle: (k1, x=100000), (k15, x=0), (k2, x=010000).
- Hold out_ready=0 for 4 cycles with continuous in_valid:
  - in_ready drops after 2 operands are accepted.
  - out_* stay stable.
  - After release, all results arrive in order with no loss or duplication.
- Assert rst while both stages are valid → out_valid=0 immediately (async), outputs zero. After release, the first new operand appears exactly 2 cycles after accept.
